// File: rtl/cp0_irq_multi_if.sv
// Core-side bus of the multi-channel CP0: register access, interrupt lines and redirect outputs.
interface cp0_irq_multi_if #(
  parameter int unsigned NUM_IRQ = 4
);
  logic [1:0]         oper;
  logic [4:0]         addr_r;
  logic [31:0]        data_r;
  logic [4:0]         addr_w;
  logic [31:0]        data_w;
  logic               ir_en;
  logic [NUM_IRQ-1:0] ir_in;
  logic [31:0]        ret_addr;
  logic               jump_en;
  logic [31:0]        jump_addr;
  logic               ir;
  logic               ir_valid;
  logic               ir_wait;

  modport master (
    output oper, addr_r, addr_w, data_w, ir_en, ir_in, ret_addr,
    input  data_r, jump_en, jump_addr, ir, ir_valid, ir_wait
  );

  modport slave (
    input  oper, addr_r, addr_w, data_w, ir_en, ir_in, ret_addr,
    output data_r, jump_en, jump_addr, ir, ir_valid, ir_wait
  );
endinterface

// File: rtl/cp0_irq_multi.sv
// CP0 with STATUS/CAUSE/EPC, NUM_IRQ edge-latched prioritised interrupts, vectored entry and ERET.
module cp0_irq_multi #(
  parameter int unsigned NUM_IRQ    = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input logic            clk,
  input logic            rst,
  cp0_irq_multi_if.slave bus
);

  typedef enum logic [1:0] {StRun, StEnter, StHandler, StReturn} state_e;

  localparam logic [1:0] OpMtc0     = 2'b10;
  localparam logic [1:0] OpEret     = 2'b11;
  localparam logic [4:0] AddrStatus = 5'd12;
  localparam logic [4:0] AddrCause  = 5'd13;
  localparam logic [4:0] AddrEpc    = 5'd14;

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] ir_in_q;
  logic [NUM_IRQ-1:0] im_q, im_d, ip_q, ip_d;
  logic               ie_q, ie_d, exl_q, exl_d;
  logic [2:0]         code_q, code_d;
  logic [31:0]        epc_q, epc_d;
  logic               jump_en_q, jump_en_d, ir_q, ir_d;
  logic [31:0]        jump_addr_q, jump_addr_d;

  logic [NUM_IRQ-1:0] rise, pend, sel_oh;
  logic [2:0]         sel;
  logic               found, req, take, eret;
  logic               wr_status, wr_cause, wr_epc;
  logic [31:0]        status_rd, cause_rd, reg_rd;

  always_comb begin
    rise   = bus.ir_in & ~ir_in_q;
    pend   = ip_q & im_q;
    req    = ie_q & ~exl_q & (|pend);
    sel    = '0;
    sel_oh = '0;
    found  = 1'b0;
    // Lowest index wins.
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      if (pend[i] && !found) begin
        found     = 1'b1;
        sel       = 3'(i);
        sel_oh[i] = 1'b1;
      end
    end
    take = (state_q == StRun) && req && bus.ir_en;
    eret = !take && (bus.oper == OpEret) && ((state_q == StRun) || (state_q == StHandler));

    wr_status = (bus.oper == OpMtc0) && (bus.addr_w == AddrStatus);
    wr_cause  = (bus.oper == OpMtc0) && (bus.addr_w == AddrCause);
    wr_epc    = (bus.oper == OpMtc0) && (bus.addr_w == AddrEpc);
  end

  always_comb begin
    state_d     = state_q;
    ie_d        = ie_q;
    im_d        = im_q;
    exl_d       = exl_q;
    code_d      = code_q;
    epc_d       = epc_q;
    ip_d        = ip_q;
    jump_en_d   = 1'b0;
    ir_d        = 1'b0;
    jump_addr_d = jump_addr_q;

    if (wr_status) begin
      ie_d = bus.data_w[0];
      im_d = bus.data_w[8 +: NUM_IRQ];
    end
    if (wr_cause) ip_d = ip_d & ~bus.data_w[8 +: NUM_IRQ];
    if (wr_epc)   epc_d = bus.data_w;

    case (state_q)
      StEnter:  state_d = StHandler;
      StReturn: state_d = StRun;
      default:  ;
    endcase

    if (take) begin
      state_d     = StEnter;
      epc_d       = bus.ret_addr;
      code_d      = sel;
      ip_d        = ip_d & ~sel_oh;
      exl_d       = 1'b1;
      jump_en_d   = 1'b1;
      ir_d        = 1'b1;
      jump_addr_d = VEC_BASE + (32'(sel) * VEC_STRIDE);
    end else if (eret) begin
      state_d     = StReturn;
      exl_d       = 1'b0;
      jump_en_d   = 1'b1;
      jump_addr_d = epc_q;
    end

    // A fresh edge overrides any clear in the same cycle.
    ip_d = ip_d | rise;
  end

  always_ff @(posedge clk) begin
    ir_in_q <= bus.ir_in;
    if (rst) begin
      state_q     <= StRun;
      ie_q        <= 1'b0;
      im_q        <= '0;
      exl_q       <= 1'b0;
      code_q      <= '0;
      epc_q       <= '0;
      ip_q        <= '0;
      jump_en_q   <= 1'b0;
      ir_q        <= 1'b0;
      jump_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      ie_q        <= ie_d;
      im_q        <= im_d;
      exl_q       <= exl_d;
      code_q      <= code_d;
      epc_q       <= epc_d;
      ip_q        <= ip_d;
      jump_en_q   <= jump_en_d;
      ir_q        <= ir_d;
      jump_addr_q <= jump_addr_d;
    end
  end

  always_comb begin
    status_rd                = '0;
    status_rd[0]             = ie_q;
    status_rd[1]             = exl_q;
    status_rd[8 +: NUM_IRQ]  = im_q;
    cause_rd                 = '0;
    cause_rd[8 +: NUM_IRQ]   = ip_q;
    cause_rd[4:2]            = code_q;
    case (bus.addr_r)
      AddrStatus: reg_rd = status_rd;
      AddrCause:  reg_rd = cause_rd;
      AddrEpc:    reg_rd = epc_q;
      default:    reg_rd = '0;
    endcase
  end

  assign bus.data_r    = ((bus.oper == OpMtc0) && (bus.addr_r == bus.addr_w)) ? bus.data_w : reg_rd;
  assign bus.jump_en   = jump_en_q;
  assign bus.jump_addr = jump_addr_q;
  assign bus.ir        = ir_q;
  assign bus.ir_valid  = req;
  assign bus.ir_wait   = req & ~bus.ir_en;

endmodule

// File: tb/tb_cp0_irq_multi.sv
// Directed and randomized bench for cp0_irq_multi against a transaction-level reference model.
module tb_cp0_irq_multi;
  localparam int          N      = 4;
  localparam logic [31:0] BASE   = 32'h0000_0100;
  localparam logic [31:0] STRIDE = 32'h0000_0010;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cp0_irq_multi_if #(.NUM_IRQ(N)) bus ();

  cp0_irq_multi #(
    .NUM_IRQ   (N),
    .VEC_BASE  (BASE),
    .VEC_STRIDE(STRIDE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: architectural registers plus "a redirect is due this cycle".
  logic        m_init = 1'b0;
  logic        m_ie, m_exl;
  logic [7:0]  m_im, m_ip, m_prev;
  logic [2:0]  m_code;
  logic [31:0] m_epc;
  logic        m_redir, m_redir_ir;
  logic [31:0] m_redir_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd();
    logic [31:0] v;
    if (bus.oper == 2'b10 && bus.addr_r == bus.addr_w) return bus.data_w;
    case (bus.addr_r)
      5'd12:   v = {16'h0, m_im, 6'h0, m_exl, m_ie};
      5'd13:   v = {16'h0, m_ip, 3'h0, m_code, 2'h0};
      5'd14:   v = m_epc;
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  function automatic logic exp_valid();
    return m_ie && !m_exl && ((m_ip & m_im) != 8'h0);
  endfunction

  task automatic model_step();
    logic [7:0]  rise, pend, nip;
    logic [31:0] old_epc;
    logic        take, eret;
    int          sel;
    if (rst) begin
      m_init = 1'b1; m_ie = 0; m_exl = 0; m_im = 0; m_ip = 0; m_code = 0; m_epc = 0;
      m_redir = 0; m_redir_ir = 0; m_redir_addr = 0;
      m_prev = {4'h0, bus.ir_in};
      return;
    end
    rise = {4'h0, bus.ir_in} & ~m_prev;
    pend = m_ip & m_im;
    sel  = 0;
    for (int i = N - 1; i >= 0; i--) if (pend[i]) sel = i;
    take = !m_redir && m_ie && !m_exl && (pend != 8'h0) && bus.ir_en;
    eret = !m_redir && !take && (bus.oper == 2'b11);
    old_epc = m_epc;
    nip = m_ip;
    if (bus.oper == 2'b10 && bus.addr_w == 5'd13) nip = nip & ~bus.data_w[15:8];
    if (take) nip[sel] = 1'b0;
    nip = (nip | rise) & 8'h0F;
    if (bus.oper == 2'b10 && bus.addr_w == 5'd12) begin
      m_ie = bus.data_w[0];
      m_im = bus.data_w[15:8] & 8'h0F;
    end
    if (take) m_epc = bus.ret_addr;
    else if (bus.oper == 2'b10 && bus.addr_w == 5'd14) m_epc = bus.data_w;
    if (take) begin
      m_redir = 1; m_redir_ir = 1; m_redir_addr = BASE + 32'(sel) * STRIDE;
      m_exl = 1; m_code = 3'(sel);
    end else if (eret) begin
      m_redir = 1; m_redir_ir = 0; m_redir_addr = old_epc; m_exl = 0;
    end else begin
      m_redir = 0;
    end
    m_ip   = nip;
    m_prev = {4'h0, bus.ir_in};
  endtask

  // One clock: check combinational outputs, advance model, check registered outputs.
  task automatic step();
    #1;
    if (m_init) begin
      chk("data_r", bus.data_r, exp_rd());
      chk("ir_valid", 32'(bus.ir_valid), 32'(exp_valid()));
      chk("ir_wait", 32'(bus.ir_wait), 32'(exp_valid() && !bus.ir_en));
    end
    model_step();
    @(posedge clk);
    #1;
    chk("jump_en", 32'(bus.jump_en), 32'(m_redir));
    chk("ir", 32'(bus.ir), 32'(m_redir && m_redir_ir));
    if (m_redir) chk("jump_addr", bus.jump_addr, m_redir_addr);
  endtask

  task automatic drv(input logic [1:0] op, input logic [4:0] aw, input logic [31:0] dw);
    bus.oper   = op;
    bus.addr_w = aw;
    bus.data_w = dw;
  endtask

  task automatic peek(input logic [4:0] a, output logic [31:0] v);
    bus.addr_r = a;
    #1;
    v = bus.data_r;
  endtask

  // From ENTER: handler cycle, ERET, RETURN cycle, back in RUN.
  task automatic finish_irq();
    drv(2'b00, 5'd0, 32'h0);
    step();
    drv(2'b11, 5'd0, 32'h0);
    step();
    drv(2'b00, 5'd0, 32'h0);
    step();
  endtask

  initial begin
    logic [31:0] rv, ret1;
    int          r;
    bus.oper = 2'b00; bus.addr_r = 5'd12; bus.addr_w = 5'd0; bus.data_w = 32'h0;
    bus.ir_en = 1'b0; bus.ir_in = '0; bus.ret_addr = 32'h0;
    rst = 1'b1;
    step();
    step();
    chk("rst_jump_addr", bus.jump_addr, 32'h0);
    rst = 1'b0;
    peek(5'd12, rv); chk("rst_status", rv, 32'h0);
    peek(5'd13, rv); chk("rst_cause", rv, 32'h0);
    peek(5'd14, rv); chk("rst_epc", rv, 32'h0);

    // Single channel entry.
    drv(2'b10, 5'd12, 32'h0000_0301);
    bus.ir_en = 1'b1;
    ret1 = $urandom & 32'hFFFF_FFFC;
    bus.ret_addr = ret1;
    step();
    drv(2'b00, 5'd0, 32'h0);
    bus.ir_in = 4'b0010;
    step();
    bus.ir_in = 4'b0000;
    step();
    chk("t1_jump_en", 32'(bus.jump_en), 32'h1);
    chk("t1_jump_addr", bus.jump_addr, 32'h0000_0110);
    chk("t1_ir", 32'(bus.ir), 32'h1);
    peek(5'd14, rv); chk("t1_epc", rv, ret1);
    peek(5'd13, rv); chk("t1_cause", rv, 32'h0000_0004);
    step();
    chk("t1_pulse_len", 32'(bus.jump_en), 32'h0);

    // Handler: new rise latched but held off, ERET to written EPC.
    drv(2'b10, 5'd14, 32'h0000_0040);
    bus.ir_in = 4'b0001;
    step();
    drv(2'b00, 5'd0, 32'h0);
    step();
    chk("t4_blocked_valid", 32'(bus.ir_valid), 32'h0);
    chk("t4_blocked_jump", 32'(bus.jump_en), 32'h0);
    drv(2'b11, 5'd0, 32'h0);
    step();
    chk("t4_eret_jump", 32'(bus.jump_en), 32'h1);
    chk("t4_eret_addr", bus.jump_addr, 32'h0000_0040);
    chk("t4_eret_ir", 32'(bus.ir), 32'h0);
    peek(5'd12, rv); chk("t4_exl_clear", rv, 32'h0000_0301);
    drv(2'b00, 5'd0, 32'h0);
    bus.ir_in = 4'b0000;
    step();
    chk("t4_no_take_in_return", 32'(bus.jump_en), 32'h0);
    step();
    chk("t4_late_take", bus.jump_addr, 32'h0000_0100);
    finish_irq();

    // Simultaneous rises, priority by lowest index.
    drv(2'b10, 5'd12, 32'h0000_0C01);
    step();
    drv(2'b00, 5'd0, 32'h0);
    bus.ir_in = 4'b1100;
    step();
    bus.ir_in = 4'b0000;
    step();
    chk("t2_prio_addr", bus.jump_addr, 32'h0000_0120);
    step();
    peek(5'd13, rv); chk("t2_cause", rv, 32'h0000_0808);
    drv(2'b11, 5'd0, 32'h0);
    step();
    chk("t2_eret_addr", bus.jump_addr, ret1);
    drv(2'b00, 5'd0, 32'h0);
    step();
    step();
    chk("t2_second_jump", 32'(bus.jump_en), 32'h1);
    chk("t2_second_addr", bus.jump_addr, 32'h0000_0130);
    peek(5'd13, rv); chk("t2_second_cause", rv, 32'h0000_000C);
    finish_irq();

    // Pending while the core cannot accept.
    bus.ir_en = 1'b0;
    bus.ir_in = 4'b0100;
    step();
    bus.ir_in = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_valid", 32'(bus.ir_valid), 32'h1);
      chk("t3_wait", 32'(bus.ir_wait), 32'h1);
      chk("t3_no_jump", 32'(bus.jump_en), 32'h0);
    end
    bus.ir_en = 1'b1;
    step();
    chk("t3_entry", bus.jump_addr, 32'h0000_0120);
    finish_irq();

    // W1C against a simultaneous rise, plus read bypass.
    drv(2'b10, 5'd12, 32'h0000_0100);
    step();
    drv(2'b00, 5'd0, 32'h0);
    bus.ir_in = 4'b0001;
    step();
    bus.ir_in = 4'b0000;
    step();
    drv(2'b10, 5'd13, 32'h0000_0100);
    bus.addr_r = 5'd13;
    bus.ir_in = 4'b0001;
    #1;
    chk("t5_bypass", bus.data_r, 32'h0000_0100);
    step();
    drv(2'b00, 5'd0, 32'h0);
    peek(5'd13, rv); chk("t5_set_wins", 32'(rv[8]), 32'h1);
    bus.ir_in = 4'b0000;
    step();
    drv(2'b10, 5'd13, 32'h0000_0100);
    step();
    drv(2'b00, 5'd0, 32'h0);
    peek(5'd13, rv); chk("t5_cleared", 32'(rv[8]), 32'h0);

    // Line held through reset is not an edge; reset during ENTER.
    bus.ir_in = 4'b0001;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    drv(2'b10, 5'd12, 32'h0000_0101);
    step();
    drv(2'b00, 5'd0, 32'h0);
    step();
    step();
    chk("t6_no_irq", 32'(bus.jump_en), 32'h0);
    chk("t6_no_valid", 32'(bus.ir_valid), 32'h0);
    peek(5'd13, rv); chk("t6_no_ip", 32'(rv[8]), 32'h0);
    bus.ir_in = 4'b0000;
    step();
    bus.ir_in = 4'b0001;
    step();
    step();
    chk("t6_enter", 32'(bus.jump_en), 32'h1);
    rst = 1'b1;
    step();
    chk("t6_rst_jump", 32'(bus.jump_en), 32'h0);
    rst = 1'b0;
    peek(5'd12, rv); chk("t6_rst_status", rv, 32'h0);
    bus.ir_in = 4'b0000;
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      r   = $urandom_range(0, 99);
      rst = (r < 2);
      r   = $urandom_range(0, 99);
      if (r < 50)      bus.oper = 2'b00;
      else if (r < 75) bus.oper = 2'b10;
      else if (r < 88) bus.oper = 2'b11;
      else             bus.oper = 2'b01;
      r = $urandom_range(0, 3);
      bus.addr_w   = (r == 3) ? 5'($urandom) : 5'(12 + r);
      r = $urandom_range(0, 3);
      bus.addr_r   = (r == 3) ? 5'($urandom) : 5'(12 + r);
      bus.data_w   = $urandom;
      bus.ir_en    = ($urandom_range(0, 3) != 0);
      bus.ret_addr = $urandom;
      if ($urandom_range(0, 3) == 0) bus.ir_in = 4'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
